// File: rtl/fpu_addsub_unit.sv
// Single-precision floating-point add/subtract unit (Compare -> Operate -> Align).
// Latency: done pulses 4 cycles after the start edge; one operation per 4 cycles.
// Backpressure: busy stalls the issuing pipeline; start while busy is dropped, no queueing.
// Ports: clk/reset_n (sync, active-low); start/op/a/b/dst request;
//        busy, done pulse, result (IEEE-754 single, truncated), result_dst.
module fpu_addsub_unit #(
    parameter int MNT_W     = 24,
    parameter int SHIFT_SAT = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  dst,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  result_dst
);
    localparam int       FRC_W = MNT_W - 1;
    localparam logic [7:0] SAT8 = 8'(SHIFT_SAT);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_OPERATE, S_ALIGN, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [4:0]       dst_q, dst_d;
    logic             spec_vld_q, spec_vld_d;
    logic [31:0]      spec_val_q, spec_val_d;
    logic             sign_q, sign_d;
    logic [7:0]       exp_q, exp_d;
    logic [MNT_W-1:0] gt_mnt_q, gt_mnt_d, lt_mnt_q, lt_mnt_d;
    logic [7:0]       e_dif_q, e_dif_d;
    logic             eff_sub_q, eff_sub_d;
    logic [MNT_W:0]   sum_q, sum_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       result_dst_q, result_dst_d;

    // Compare-stage helpers
    logic             a_ge_b;
    logic [31:0]      gt_op, lt_op;
    logic             a_zero, b_zero;
    // Operate-stage helpers
    logic [MNT_W-1:0] lt_sh;
    // Align-stage helpers
    logic [4:0]       lzc;
    logic signed [9:0] exp_adj;
    logic [FRC_W-1:0] frac_n;
    logic [31:0]      norm_res;

    always_comb begin
        // Ties choose A since >= favours it.
        a_ge_b = a_q[30:0] >= b_q[30:0];
        gt_op  = a_ge_b ? a_q : b_q;
        lt_op  = a_ge_b ? b_q : a_q;
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);

        lt_sh = (e_dif_q >= SAT8) ? '0 : (lt_mnt_q >> e_dif_q);

        // Highest set bit wins: scan upward so the last hit is the MSB.
        lzc = 5'd0;
        for (int i = 0; i < MNT_W; i++) begin
            if (sum_q[i]) lzc = 5'(MNT_W - 1 - i);
        end

        if (sum_q[MNT_W]) begin
            exp_adj = $signed({2'b00, exp_q}) + 10'sd1;
            frac_n  = sum_q[MNT_W-1:1];
        end else begin
            exp_adj = $signed({2'b00, exp_q}) - $signed({5'b00000, lzc});
            // Hidden bit lands on bit FRC_W after the shift, so only the
            // fraction bits below it need shifting.
            frac_n  = sum_q[FRC_W-1:0] << lzc;
        end

        if (sum_q == '0) begin
            norm_res = 32'h0000_0000;
        end else if (exp_adj >= 10'sd255) begin
            norm_res = {sign_q, 8'hFF, 23'h0};
        end else if (exp_adj <= 10'sd0) begin
            norm_res = {sign_q, 31'h0};
        end else begin
            norm_res = {sign_q, exp_adj[7:0], frac_n};
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        dst_d        = dst_q;
        spec_vld_d   = spec_vld_q;
        spec_val_d   = spec_val_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        gt_mnt_d     = gt_mnt_q;
        lt_mnt_d     = lt_mnt_q;
        e_dif_d      = e_dif_q;
        eff_sub_d    = eff_sub_q;
        sum_d        = sum_q;
        result_d     = result_q;
        result_dst_d = result_dst_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = {b[31] ^ op, b[30:0]};
                    dst_d   = dst;
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                sign_d    = gt_op[31];
                exp_d     = gt_op[30:23];
                gt_mnt_d  = {1'b1, gt_op[22:0]};
                lt_mnt_d  = {1'b1, lt_op[22:0]};
                e_dif_d   = gt_op[30:23] - lt_op[30:23];
                eff_sub_d = gt_op[31] ^ lt_op[31];
                // Specials bypass the datapath; inf/NaN pass through, A first.
                spec_vld_d = 1'b1;
                if (a_q[30:23] == 8'hFF)      spec_val_d = a_q;
                else if (b_q[30:23] == 8'hFF) spec_val_d = b_q;
                else if (a_zero && b_zero)    spec_val_d = 32'h0000_0000;
                else if (a_zero)              spec_val_d = b_q;
                else if (b_zero)              spec_val_d = a_q;
                else begin
                    spec_vld_d = 1'b0;
                    spec_val_d = 32'h0000_0000;
                end
                state_d = S_OPERATE;
            end
            S_OPERATE: begin
                sum_d   = eff_sub_q ? ({1'b0, gt_mnt_q} - {1'b0, lt_sh})
                                    : ({1'b0, gt_mnt_q} + {1'b0, lt_sh});
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                result_d     = spec_vld_q ? spec_val_q : norm_res;
                result_dst_d = dst_q;
                state_d      = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            dst_q        <= '0;
            spec_vld_q   <= 1'b0;
            spec_val_q   <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            gt_mnt_q     <= '0;
            lt_mnt_q     <= '0;
            e_dif_q      <= '0;
            eff_sub_q    <= 1'b0;
            sum_q        <= '0;
            result_q     <= '0;
            result_dst_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            dst_q        <= dst_d;
            spec_vld_q   <= spec_vld_d;
            spec_val_q   <= spec_val_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            gt_mnt_q     <= gt_mnt_d;
            lt_mnt_q     <= lt_mnt_d;
            e_dif_q      <= e_dif_d;
            eff_sub_q    <= eff_sub_d;
            sum_q        <= sum_d;
            result_q     <= result_d;
            result_dst_q <= result_dst_d;
        end
    end

    assign busy       = (state_q == S_COMPARE) || (state_q == S_OPERATE) || (state_q == S_ALIGN);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign result_dst = result_dst_q;

endmodule

// File: tb/tb_fpu_addsub_unit.sv
module tb_fpu_addsub_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic [4:0]  dst;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  result_dst;

    int checks = 0;
    int errors = 0;

    fpu_addsub_unit #(.MNT_W(24), .SHIFT_SAT(25)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .dst        (dst),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_dst (result_dst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [4:0]  dst;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done. lat=0 means no done seen.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                         input logic [4:0] idst, output int lat, output int bcnt,
                         output logic [31:0] res, output logic [4:0] rdst);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; op = iop; dst = idst;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; bcnt = 0; res = 'x; rdst = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = c; res = result; rdst = result_dst;
                break;
            end
        end
    endtask

    initial begin
        int          lat, bcnt, ndone;
        logic [31:0] res;
        logic [4:0]  rdst;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 5'd5,  32'h40000000}; // 1+1
        vecs[1]  = '{32'h40400000, 32'h40A00000, 1'b1, 5'd6,  32'hC0000000}; // 3-5, swap
        vecs[2]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 5'd7,  32'h00000000}; // cancel
        vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 5'd8,  32'h3F800000}; // e_dif 30
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd9,  32'h7F800000}; // overflow
        vecs[5]  = '{32'h3F800000, 32'h34000000, 1'b0, 5'd10, 32'h3F800001}; // e_dif 23
        vecs[6]  = '{32'h40000000, 32'h3F800000, 1'b1, 5'd11, 32'h3F800000}; // 2-1
        vecs[7]  = '{32'hBF800000, 32'h40000000, 1'b0, 5'd12, 32'h3F800000}; // -1+2
        vecs[8]  = '{32'h00000000, 32'h40400000, 1'b1, 5'd13, 32'hC0400000}; // 0-3
        vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 5'd14, 32'h7F800000}; // inf+1
        vecs[10] = '{32'h80000000, 32'h00000000, 1'b0, 5'd15, 32'h00000000}; // -0+0
        vecs[11] = '{32'h00800000, 32'h00C00000, 1'b1, 5'd16, 32'h80000000}; // underflow

        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; dst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_dst", 32'(result_dst), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].dst, lat, bcnt, res, rdst);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_dst", i), 32'(rdst), 32'(vecs[i].dst));
            if (i == 0) chk("vec0_busy_cycles", 32'(bcnt), 32'd3);
        end

        // Result holds after done until the next one.
        repeat (3) @(negedge clk);
        chk("hold_result", result, 32'h80000000);
        chk("hold_dst", 32'(result_dst), 32'd16);

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1; a = 32'h40400000; b = 32'h40A00000; op = 1'b1; dst = 5'd3;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; a = 32'h40000000; b = 32'h40000000; op = 1'b0; dst = 5'd9;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("busy_ignore_count", 32'(ndone), 32'd1);
        chk("busy_ignore_result", result, 32'hC0000000);
        chk("busy_ignore_dst", 32'(result_dst), 32'd3);

        // Reset during OPERATE discards the request.
        @(negedge clk);
        start = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; dst = 5'd21;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);          // COMPARE
        @(negedge clk);          // OPERATE
        chk("mid_busy_before_reset", 32'(busy), 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_busy", 32'(busy), 32'h0);
        chk("mid_reset_done", 32'(done), 32'h0);
        chk("mid_reset_result", result, 32'h0);
        reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_stale_done", 32'(ndone), 32'd0);

        // Fresh start after reset completes normally.
        do_op(32'h40400000, 32'h40A00000, 1'b0, 5'd30, lat, bcnt, res, rdst);
        chk("post_reset_latency", 32'(lat), 32'd4);
        chk("post_reset_result", res, 32'h41000000); // 3+5 = 8
        chk("post_reset_dst", 32'(rdst), 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_unit.md
Name: fpu_addsub_unit

Overview:
- Multi-cycle single-precision floating-point add/subtract unit.
- Answers the decode/execute side's FPU start request (ADDS path) and returns a result to the FP writeback path.
- Three internal stages in sequence: Compare (order operands by magnitude), Operate (align and add/subtract mantissas), Align (normalize and pack).
- Start/busy/done handshake; `busy` feeds the hazard unit so the pipeline stalls while the unit is occupied.

Parameters:
- MNT_W, 24, mantissa width including hidden bit.
- SHIFT_SAT, 25, alignment shift at or above which the smaller operand becomes 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset: synchronous and active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  1  0 = a+b, 1 = a−b.
- a  in  32  operand A, IEEE-754 single.
- b  in  32  operand B, IEEE-754 single.
- dst  in  5  destination FP register address.
- busy  out  1  high while in COMPARE, OPERATE or ALIGN.
- done  out  1  one-cycle pulse; result and result_dst are valid.
- result  out  32  packed IEEE-754 result.
- result_dst  out  5  dst captured with the request.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state→IDLE; busy=0, done=0, result=0, result_dst=0.
  - Reset applies mid-operation too; the in-flight request is discarded and no done is produced.
- FSM: IDLE → COMPARE → OPERATE → ALIGN → DONE → IDLE.
  - IDLE/DONE with start=1 at edge N: latch a, b^{op<<31}, dst; state=COMPARE at N+1.
  - Start accepted in DONE gives back-to-back operation.
  - done=1 during cycle N+4; latency is 4 cycles from the start edge.
  - Throughput is one operation per 4 cycles.
- start while busy=1 is ignored; no queueing.
- result and result_dst hold their last value until the next done.
- COMPARE:
  - gt = operand with the larger {exp,mnt}; ties choose A.
  - e_dif = gt.exp − lt.exp (8-bit, unsigned).
  - Record an effective-subtract flag = gt.sign ^ lt.sign.
- OPERATE:
  - Extend mantissas with the hidden bit (24 bits).
  - lt_mnt >>= e_dif; if e_dif ≥ SHIFT_SAT, lt_mnt = 0.
  - 25-bit sum = gt_mnt ± lt_mnt.
  - Sign = gt.sign; exponent = gt.exp.
- ALIGN (normalize), combinational within the stage:
  - If sum[24]: shift right 1, exp+1.
  - Else: leading-zero count on sum[23:0]; shift left by the count, exp −= count.
  - sum == 0 → result = 0x00000000 (+0).
  - Exponent ≥ 255 after adjust → ±inf (exp=0xFF, mnt=0).
  - Exponent ≤ 0 after adjust → signed zero (flush).
  - Rounding is truncation; there are no guard/sticky bits.
- Special inputs, resolved in COMPARE (OPERATE/ALIGN then pass the value through):
  - Operand with exp=0 is treated as ±0 (denormals flushed).
  - If one operand is zero, result = the other effective operand.
  - Both zero → +0.
  - Operand with exp=0xFF → result = that effective operand, A has priority; NaN/inf semantics beyond pass-through are out of scope.
- Signed arithmetic only on the exponent adjust: 10-bit signed intermediate to detect overflow and underflow.

Test Plan:
- a=0x3F800000, b=0x3F800000, op=0, dst=5 → done exactly 4 cycles after the start edge; result=0x40000000, result_dst=5; busy high 3 cycles.
- a=0x40400000 (3.0), b=0x40A00000 (5.0), op=1 → result=0xC0000000 (−2.0); exercises swap and left-normalize.
- a=0x3FC00000, b=0x3FC00000, op=1 → result=0x00000000 (exact cancellation gives +0).
- a=0x3F800000, b=0x30800000 (2^−30), op=0 → result=0x3F800000 (e_dif=30 saturates the shift).
- a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 → result=0x7F800000 (overflow to +inf).
- Control:
  - Start while busy with a=0x40000000 → ignored; only the first request's done occurs.
  - reset_n=0 during OPERATE → busy=0, done=0 next cycle, no stale done.
  - A fresh start then completes normally.
